// File: rtl/bp_me_pkg.sv
// Shared definitions for the memory-end arbiter: requester IDs, configuration
// selection and the derived CCE<->memory message width.
// No logic; latency and backpressure are properties of the modules that import this.
package bp_me_pkg;

    // Requester identity, also the payload stored in the arbiter's order FIFO.
    typedef enum logic [0:0] {
        e_mem_req_icache = 1'b0,
        e_mem_req_dcache = 1'b1
    } bp_mem_req_id_e;

    // Processor configurations that size the memory message.
    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_small_cfg   = 2'd1
    } bp_params_e;

    // Default number of commands allowed in flight to memory.
    localparam int bp_me_arb_els_dp = 4;

    // Fixed header fields that do not depend on the configuration.
    localparam int bp_mem_msg_type_width_gp = 4;
    localparam int bp_mem_msg_size_width_gp = 3;

    function automatic int bp_paddr_width(input bp_params_e cfg);
        return (cfg == e_bp_small_cfg) ? 32 : 40;
    endfunction

    function automatic int bp_cce_block_width(input bp_params_e cfg);
        return (cfg == e_bp_small_cfg) ? 256 : 512;
    endfunction

    function automatic int bp_lce_id_width(input bp_params_e cfg);
        return (cfg == e_bp_small_cfg) ? 2 : 4;
    endfunction

    function automatic int bp_lce_assoc(input bp_params_e cfg);
        return (cfg == e_bp_small_cfg) ? 4 : 8;
    endfunction

    // Message = type + size + paddr + {lce_id, way_id} payload + data block.
    function automatic int bp_cce_mem_msg_width(input bp_params_e cfg);
        return bp_mem_msg_type_width_gp
             + bp_mem_msg_size_width_gp
             + bp_paddr_width(cfg)
             + bp_lce_id_width(cfg)
             + $clog2(bp_lce_assoc(cfg))
             + bp_cce_block_width(cfg);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO, one write and one read port; ports: v_i/ready_o/data_i in, v_o/data_o/yumi_i out.
// Latency: an entry written in cycle N is visible on data_o in cycle N+1 (no bypass).
// Backpressure: ready_o drops when all els_p entries are occupied; reads are consumed by yumi_i.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_width_lp = $clog2(els_p + 1);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] rptr_r, wptr_r;
    logic [cnt_width_lp-1:0] cnt_r;
    logic                    enq, deq;

    assign ready_o = (cnt_r != cnt_width_lp'(els_p));
    assign v_o     = (cnt_r != '0);
    assign data_o  = mem_r[rptr_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Pointers wrap explicitly so els_p need not be a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r <= '0;
            wptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (enq) wptr_r <= (wptr_r == last_ptr_lp) ? '0 : wptr_r + 1'b1;
            if (deq) rptr_r <= (rptr_r == last_ptr_lp) ? '0 : rptr_r + 1'b1;
            case ({enq, deq})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by cnt_r.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bp_me_mem_arbiter.sv
// Two-requester round-robin arbiter onto one in-order memory port, routing responses back by grant order.
// Latency: command path is combinational (zero cycles); response routing is combinational from the order FIFO head.
// Backpressure: grants stop when memory is not ready or els_p commands are outstanding; a stalled
// response consumer blocks only the response path.
// Ports: mem_cmd{0,1}_* requester commands in, mem_resp{0,1}_* responses out, mem_cmd_*/mem_resp_* to/from
// bp_mem, outstanding_o in-flight count, error_o sticky orphan-response flag.
module bp_me_mem_arbiter
    import bp_me_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int         els_p       = bp_me_arb_els_dp,
    localparam int        cce_mem_msg_width_lp = bp_cce_mem_msg_width(bp_params_p),
    localparam int        cnt_width_lp         = $clog2(els_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd0_i,
    input  logic                            mem_cmd0_v_i,
    output logic                            mem_cmd0_yumi_o,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd1_i,
    input  logic                            mem_cmd1_v_i,
    output logic                            mem_cmd1_yumi_o,

    output logic [cce_mem_msg_width_lp-1:0] mem_resp0_o,
    output logic                            mem_resp0_v_o,
    input  logic                            mem_resp0_ready_i,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp1_o,
    output logic                            mem_resp1_v_o,
    input  logic                            mem_resp1_ready_i,

    output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
    output logic                            mem_cmd_v_o,
    input  logic                            mem_cmd_ready_i,

    input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
    input  logic                            mem_resp_v_i,
    output logic                            mem_resp_yumi_o,

    output logic [cnt_width_lp-1:0]         outstanding_o,
    output logic                            error_o
);

    bp_mem_req_id_e            last_r;
    logic [cnt_width_lp-1:0]   cnt_r;
    logic                      error_r;

    logic                      live;
    logic                      can_grant, grant0, grant1, grant_any;
    logic                      fifo_ready, fifo_v;
    logic [0:0]                fifo_head;
    logic                      head_is_icache;
    logic                      resp_deq, orphan;

    // All handshakes are held low while in reset.
    assign live = ~reset_i;

    // Full check uses the registered count only, so a same-cycle response
    // dequeue never frees a slot early.
    assign can_grant = live & mem_cmd_ready_i & fifo_ready
                     & (cnt_r < cnt_width_lp'(els_p));

    // On a tie the requester that did not win last time goes.
    assign grant0    = can_grant & mem_cmd0_v_i
                     & (~mem_cmd1_v_i | (last_r == e_mem_req_dcache));
    assign grant1    = can_grant & mem_cmd1_v_i
                     & (~mem_cmd0_v_i | (last_r == e_mem_req_icache));
    assign grant_any = grant0 | grant1;

    assign mem_cmd0_yumi_o = grant0;
    assign mem_cmd1_yumi_o = grant1;
    assign mem_cmd_v_o     = grant_any;
    assign mem_cmd_o       = grant1 ? mem_cmd1_i : mem_cmd0_i;

    // Grant order: memory answers in order, so the FIFO head names the owner
    // of the response currently presented.
    bsg_fifo_1r1w_small #(
        .width_p (1),
        .els_p   (els_p)
    ) order_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (grant_any),
        .ready_o (fifo_ready),
        .data_i  (grant1),
        .v_o     (fifo_v),
        .data_o  (fifo_head),
        .yumi_i  (resp_deq)
    );

    assign head_is_icache = (bp_mem_req_id_e'(fifo_head) == e_mem_req_icache);

    assign mem_resp0_o   = mem_resp_i;
    assign mem_resp1_o   = mem_resp_i;
    assign mem_resp0_v_o = live & mem_resp_v_i & fifo_v &  head_is_icache;
    assign mem_resp1_v_o = live & mem_resp_v_i & fifo_v & ~head_is_icache;

    assign resp_deq = (mem_resp0_v_o & mem_resp0_ready_i)
                    | (mem_resp1_v_o & mem_resp1_ready_i);

    // A response with nobody waiting for it is swallowed so memory cannot
    // wedge; the error flag records that tracking was lost.
    assign orphan          = live & mem_resp_v_i & ~fifo_v;
    assign mem_resp_yumi_o = resp_deq | orphan;

    assign outstanding_o = cnt_r;
    assign error_o       = error_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_r  <= e_mem_req_dcache;
            cnt_r   <= '0;
            error_r <= 1'b0;
        end else begin
            if (grant_any) begin
                last_r <= grant1 ? e_mem_req_dcache : e_mem_req_icache;
            end
            case ({grant_any, resp_deq})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
            if (orphan) error_r <= 1'b1;
        end
    end

endmodule

// File: doc/bp_me_mem_arbiter.md
BP_ME_MEM_ARBITER -- requirements
Module: bp_me_mem_arbiter

Interface
REQ-001 Parameter bp_params_p, default e_bp_default_cfg; selects paddr_width_p, cce_block_width_p, lce_id_width_p and lce_assoc_p, which set cce_mem_msg_width_lp.
REQ-002 Parameter els_p, default 4; maximum commands outstanding to memory, range 2..16.
REQ-003 Port clk_i, input, 1: single clock, all state on posedge.
REQ-004 Port reset_i, input, 1: reset, synchronous, active-high.
REQ-005 Port mem_cmd0_i, input, cce_mem_msg_width_lp: requester 0 (I$ wrapper) command.
REQ-006 Port mem_cmd0_v_i / mem_cmd0_yumi_o, input / output, 1 each: requester 0 valid, and the arbiter's consume strobe back to it.
REQ-007 Port mem_cmd1_i, mem_cmd1_v_i, mem_cmd1_yumi_o: same as REQ-005/006 for requester 1.
REQ-008 Port mem_resp0_o, output, cce_mem_msg_width_lp: response to requester 0; mem_resp0_v_o output 1; mem_resp0_ready_i input 1.
REQ-009 Port mem_resp1_o, mem_resp1_v_o, mem_resp1_ready_i: same as REQ-008 for requester 1.
REQ-010 Port mem_cmd_o / mem_cmd_v_o / mem_cmd_ready_i, output / output / input: to bp_mem.
REQ-011 Port mem_resp_i / mem_resp_v_i / mem_resp_yumi_o, input / input / output: from bp_mem.
REQ-012 Port outstanding_o, output, $clog2(els_p+1): count of granted commands whose responses have not been consumed.
REQ-013 Port error_o, output, 1: sticky flag; set by an orphan response.

Function
REQ-014 Grant condition: at least one requester valid, mem_cmd_ready_i=1 and outstanding_o<els_p; no grant otherwise.
REQ-015 Arbitration is round-robin: if both requesters are valid, grant the one not granted last; if only one is valid, grant it.
REQ-016 The last-granted pointer updates only on a grant.
REQ-017 mem_cmd_o/mem_cmd_v_o reflect the granted requester combinationally (zero latency); mem_cmdN_yumi_o equals grantN.
REQ-018 mem_cmd_v_o is never asserted without a grant, so mem_cmd_v_o implies mem_cmd_ready_i.
REQ-019 Each grant enqueues the granted requester ID into an order FIFO of depth els_p.
REQ-020 Responses are in order: mem_resp_i is routed to the requester at the FIFO head.
REQ-021 mem_respN_o equals mem_resp_i for both N, unconditionally.
REQ-022 mem_respN_v_o = mem_resp_v_i & fifo_v & (head==N).
REQ-023 mem_resp_yumi_o = mem_respN_v_o & mem_respN_ready_i for the head requester; FIFO dequeues on mem_resp_yumi_o.
REQ-024 Orphan response: mem_resp_v_i=1 while the FIFO is empty. The response is yumi'd (dropped), no requester valid is raised, and error_o is set until reset.
REQ-025 outstanding_o adds 1 on grant and subtracts 1 on a non-orphan yumi; both in one cycle leaves it unchanged.
REQ-026 The full check uses the registered count, so no grant occurs at els_p even if a dequeue happens in the same cycle.
REQ-027 A response arriving in the grant cycle with the FIFO empty counts as an orphan: bp_mem has at least 1 cycle of latency.
REQ-028 A stalled requester (ready_i=0) blocks responses only; command grants continue up to els_p.

Reset
REQ-029 On reset_i: FIFO empty, outstanding_o=0, error_o=0, last-granted=1 (requester 0 wins the first tie).
REQ-030 During reset all v_o and yumi_o outputs are 0.
REQ-031 Reset mid-operation discards all tracking; responses from pre-reset commands that arrive after reset are orphans (REQ-024).

Structure
REQ-032 The requester ID enum (e_mem_req_icache=0, e_mem_req_dcache=1) and the default els_p belong in bp_me_pkg.
REQ-033 The order FIFO is one sub-module, bsg_fifo_1r1w_small, width 1, els_p entries.
REQ-034 The remaining logic (round-robin pointer, counter, error flag) is inline, about 150 lines.

Verification
REQ-035 Reset, then only requester 0 valid with 3 commands and ready_i=1 -> 3 grants on consecutive cycles, outstanding_o reaches 3, responses go only to port 0, outstanding_o returns to 0.
REQ-036 Both requesters valid continuously, els_p=4, latency 15 -> grant order 0,1,0,1; no grant while outstanding_o=4; responses alternate 0,1,0,1.
REQ-037 Responses in flight for requesters 1 then 0, with mem_resp1_ready_i=0 for 5 cycles -> mem_resp_yumi_o=0 for those 5 cycles and requester 0's response is not delivered early.
REQ-038 mem_resp_v_i=1 with the FIFO empty -> mem_resp_yumi_o=1, both mem_respN_v_o=0, error_o=1 and held.
REQ-039 Assert reset_i with 2 responses pending; bp_mem returns both after reset -> both treated as orphans, error_o=1, outstanding_o stays 0.
REQ-040 mem_cmd_ready_i=0 with both requesters valid -> no yumi, pointer unchanged; on the first ready cycle the requester after the last granted wins.
